// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Constants and types shared by the UART receiver and transmitter.
//   FREQ  : system clock frequency in Hz
//   BAUD  : serial line rate in bits/s
//   CLKS  : clock cycles per bit (integer division, truncated)
//   HALF  : cycles from start-edge detection to the start-bit mid-sample
//   CNT_W : width of the per-bit baud counter
//   rx_state_t : receiver FSM state encoding
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int FREQ  = 27000000;
    localparam int BAUD  = 115200;
    localparam int CLKS  = FREQ / BAUD;
    localparam int HALF  = CLKS / 2;
    localparam int CNT_W = $clog2(CLKS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// ----------------------------------------------------------------------------
// uart_sync
// Two-flop synchronizer for a single asynchronous input. The reset value is a
// parameter so an idle-high line (such as a UART rx pin) reads idle straight
// out of reset.
// Ports:
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset, loads RST_VAL into both flops
//   i_d     : asynchronous input
//   o_q     : synchronized output, 2 cycles after i_d
// ----------------------------------------------------------------------------
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/rx_uart.sv
// ----------------------------------------------------------------------------
// rx_uart
// 8N1 UART receiver. Recovers bytes from the serial rx pin and presents each
// one in a valid/ready holding register.
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   rx        : asynchronous serial input, idle high
//   data      : received byte, stable while valid=1
//   valid     : holding register contains a byte
//   ready     : consumer accepts; a transfer happens on any cycle with
//               valid && ready
//   frame_err : one-cycle pulse, stop bit sampled low (byte discarded)
//   overrun   : one-cycle pulse, good byte completed while the holding
//               register was still full and not being drained (byte dropped)
// ----------------------------------------------------------------------------
module rx_uart
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    logic             w_rx_s;
    rx_state_t        r_state;
    rx_state_t        w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic             w_sample;
    logic             w_good;
    logic             w_bad;
    logic             w_load;

    uart_sync #(
        .RST_VAL (1'b1)
    ) u_sync (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_d     (rx),
        .o_q     (w_rx_s)
    );

    // Next state and sample strobes. A sample point is the last cycle of a
    // counting period: HALF cycles into START, CLKS cycles into every later bit.
    always_comb begin
        w_next_state = r_state;
        w_sample     = 1'b0;
        w_good       = 1'b0;
        w_bad        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_next_state = START;
                end
            end
            START: begin
                if (r_cnt == CNT_W'(HALF - 1)) begin
                    w_sample = 1'b1;
                    // Line back high at mid start bit: treat as a glitch.
                    w_next_state = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == CNT_W'(CLKS - 1)) begin
                    w_sample = 1'b1;
                    if (r_bit == 3'd7) begin
                        w_next_state = STOP;
                    end
                end
            end
            STOP: begin
                if (r_cnt == CNT_W'(CLKS - 1)) begin
                    w_sample = 1'b1;
                    if (w_rx_s) begin
                        w_good       = 1'b1;
                        w_next_state = IDLE;
                    end else begin
                        w_bad        = 1'b1;
                        w_next_state = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // Hold here through a break so it reports only one error.
                if (w_rx_s) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // A good byte may enter the holding register when it is empty or is
    // being drained on this very cycle.
    assign w_load = w_good && (!r_valid || ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_bit       <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            // Baud counter restarts on every state entry and every sample.
            if ((w_next_state != r_state) || w_sample) begin
                r_cnt <= '0;
            end else if (r_state == START || r_state == DATA || r_state == STOP) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (r_state == START && w_sample) begin
                r_bit <= 3'd0;
            end else if (r_state == DATA && w_sample) begin
                r_bit <= r_bit + 3'd1;
            end

            // LSB arrives first, so shift in from the top.
            if (r_state == DATA && w_sample) begin
                r_shift <= {w_rx_s, r_shift[7:1]};
            end

            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end

            r_frame_err <= w_bad;
            r_overrun   <= w_good && r_valid && !ready;
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_rx_uart.sv
// ----------------------------------------------------------------------------
// tb_rx_uart
// Self-checking bench for rx_uart. A reference model predicts, per frame, the
// event the receiver should report (byte transfer, framing error or overrun)
// and when; a monitor pops and compares every event the DUT presents.
// ----------------------------------------------------------------------------
module tb_rx_uart;
    import uart_pkg::*;

    localparam logic [1:0] K_BYTE = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;
    localparam logic [1:0] K_OVR  = 2'd3;
    // Pin fall to output: 2 sync cycles, half a start bit, 8 data bits,
    // the stop bit, plus one cycle for the output register.
    localparam longint LAT = 2 + HALF + 9 * CLKS + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    rx_uart dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int         n_vec = 0;
    int         n_err = 0;
    logic [9:0] exp_q[$];
    longint     exp_t_q[$];
    bit         m_full = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         prev_vr = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input logic [1:0] k, input logic [7:0] d, input longint t);
        exp_q.push_back({k, d});
        exp_t_q.push_back(t);
    endtask

    // Reference model: what one frame should produce, given the holding
    // register occupancy the bench has set up through ready.
    task automatic model_frame(input logic [7:0] b, input bit stop_ok, input longint t_done);
        if (!stop_ok) begin
            push_exp(K_ERR, 8'h00, t_done);
        end else if (m_full) begin
            push_exp(K_OVR, 8'h00, t_done);
        end else if (ready) begin
            push_exp(K_BYTE, b, t_done);
        end else begin
            m_full = 1'b1;
            m_data = b;
        end
    endtask

    task automatic mon_event(input logic [1:0] k, input logic [7:0] d);
        logic [9:0] e;
        longint     t;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d data 0x%02h, expected none at cycle %0d", k, d, cyc);
        end else begin
            e = exp_q.pop_front();
            t = exp_t_q.pop_front();
            check("event", {54'd0, k, d}, {54'd0, e});
            if (t >= 0) check("event_time", cyc, t);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (prev_vr) check("valid_drop", {63'd0, valid}, 64'd0);
        prev_vr = valid && ready;
        if (valid && ready) mon_event(K_BYTE, data);
        if (frame_err) mon_event(K_ERR, 8'h00);
        if (overrun) mon_event(K_OVR, 8'h00);
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_wait();
        idle(CLKS);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1;
        ready = r;
        if (r && m_full) begin
            push_exp(K_BYTE, m_data, -1);
            m_full = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int hold_low);
        @(posedge clk);
        #1;
        model_frame(b, stop_ok, cyc + LAT);
        rx = 1'b0;
        bit_wait();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            bit_wait();
        end
        rx = stop_ok;
        bit_wait();
        if (hold_low > 0) idle(hold_low);
        rx = 1'b1;
    endtask

    task automatic check_outputs(input string name, input logic [7:0] d, input logic v);
        check({name, "_data"}, {56'd0, data}, {56'd0, d});
        check({name, "_valid"}, {63'd0, valid}, {63'd0, v});
        check({name, "_frame_err"}, {63'd0, frame_err}, 64'd0);
        check({name, "_overrun"}, {63'd0, overrun}, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] b;
    bit         ok;

    initial begin
        rst   = 1'b0;
        rx    = 1'b1;
        ready = 1'b1;
        idle(5);
        check_outputs("reset", 8'h00, 1'b0);
        rst = 1'b1;

        // Quiet line: nothing may come out.
        idle(5000);
        check_outputs("idle", 8'h00, 1'b0);

        // Single good frame, consumer always ready.
        send_frame(8'h41, 1'b1, 0);
        check_outputs("frame41", 8'h41, 1'b0);

        // Short low glitch is rejected, next frame still lands.
        rx = 1'b0;
        idle(50);
        rx = 1'b1;
        idle(300);
        check_outputs("glitch", 8'h41, 1'b0);
        send_frame(8'h5A, 1'b1, 0);
        check("frame5A_data", {56'd0, data}, 64'h5A);

        // Bad stop bit followed by a long break: exactly one frame error.
        send_frame(8'h55, 1'b0, 3000);
        idle(20);
        check("break_data", {56'd0, data}, 64'h5A);
        send_frame(8'h0F, 1'b1, 0);
        check("frame0F_data", {56'd0, data}, 64'h0F);

        // Holding register full: second byte dropped with an overrun.
        set_ready(1'b0);
        send_frame(8'h41, 1'b1, 0);
        check("hold_valid", {63'd0, valid}, 64'd1);
        check("hold_data", {56'd0, data}, 64'h41);
        send_frame(8'h42, 1'b1, 0);
        check("ovr_valid", {63'd0, valid}, 64'd1);
        check("ovr_data", {56'd0, data}, 64'h41);
        set_ready(1'b1);
        idle(3);
        check("drained_valid", {63'd0, valid}, 64'd0);

        // Reset in the middle of data bit 4 aborts the frame silently.
        b = 8'hC3;
        @(posedge clk);
        #1;
        rx = 1'b0;
        bit_wait();
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            bit_wait();
        end
        rx = b[4];
        idle(CLKS / 2);
        rst    = 1'b0;
        rx     = 1'b1;
        m_full = 1'b0;
        idle(3);
        check_outputs("midreset", 8'h00, 1'b0);
        rst = 1'b1;
        idle(10);
        check_outputs("post_reset", 8'h00, 1'b0);
        send_frame(8'h7E, 1'b1, 0);
        check("frame7E_data", {56'd0, data}, 64'h7E);

        // Randomized frames, stop errors and glitches.
        for (int n = 0; n < 16; n++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                rx = 1'b0;
                idle($urandom_range(1, 80));
                rx = 1'b1;
                idle(200);
            end
            send_frame(b, ok, 0);
            idle(ok ? $urandom_range(0, 40) : $urandom_range(4, 40));
        end

        idle(20);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rx_uart.md
Name: rx_uart

Overview:
- UART receiver: the receive-side counterpart of the team's 8N1 UART transmitter (27 MHz clock, 115200 baud).
- Recovers bytes from the serial `rx` pin (PC to FPGA) and presents each one on a valid/ready holding register.
- Flags framing errors and overruns.
- Sits between the board RX pin and any byte consumer, e.g. an echo path feeding the transmitter.

Parameters:
- FREQ, 27000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- CLKS, FREQ/BAUD (=234), clock cycles per bit. Integer division; no rounding.
- HALF, CLKS/2 (=117), cycles from start-edge detection to the start-bit mid-sample.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx  in  1  asynchronous serial input; idle high.
- data  out  8  received byte, held stable while valid=1.
- valid  out  1  byte available in the holding register.
- ready  in  1  consumer accepts; a transfer occurs on a cycle with valid&&ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: byte completed while the holding register was still full.

Behaviour:
- Reset (rst=0, asynchronous):
  - data=0x00, valid=0, frame_err=0, overrun=0.
  - State IDLE, bit and baud counters 0.
  - Both synchronizer flops set to 1, so the synchronized line reads idle.
  - Reset mid-frame aborts the frame silently.
- rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s only. Latency from pin to rx_s is 2 cycles.
- Baud counter width is $clog2(CLKS). It clears on every state entry and on every sample.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on the first cycle with rx_s=0 (cycle t0), go to START with cnt=0.
  - START: at t0+HALF, sample rx_s.
    - 0 → DATA, bit index 0.
    - 1 → IDLE. This is glitch rejection: no output and no error.
  - DATA: sample every CLKS cycles. Bit k (LSB first) is sampled at t0+HALF+CLKS*(k+1) and shifted into the shift register. After bit 7 is sampled, go to STOP.
  - STOP: sample at t0+HALF+9*CLKS (=t0+2223).
    - rx_s=1: frame is good → IDLE.
    - rx_s=0: frame_err pulses 1 cycle, byte is discarded → WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE. A break condition therefore produces exactly one frame_err.
- Output register on a good frame:
  - If valid=0, or valid&&ready on that same cycle: data←shift register and valid=1 from cycle t0+2224.
  - Otherwise (valid=1 and ready=0): new byte dropped, data unchanged, overrun pulses 1 cycle.
- valid falls the cycle after valid&&ready, unless a new byte is loaded on that same cycle; in that case valid stays 1 and data updates.
- A new start edge is accepted on the cycle IDLE is re-entered. No minimum gap beyond the stop-bit half-period.
- frame_err and overrun are never asserted in the same cycle as each other for the same frame.

Decomposition:
- Package uart_pkg holds:
  - FREQ, BAUD, CLKS, HALF constants, shared with the transmitter.
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, STOP, WAIT_IDLE}.
- One sub-module, uart_sync: 2-flop synchronizer with parameterized reset value (1 for rx). It is reusable for other asynchronous inputs.

Test Plan:
- Reset release, rx=1 for 5000 cycles → valid, frame_err and overrun stay 0; data=0x00.
- Frame 0x41 at 234 cycles/bit with ready=1 → valid=1 exactly 2226 cycles after the rx pin falls (2 synchronizer + 2224), data=0x41. valid drops the next cycle. No frame_err.
- rx low for 50 cycles then high → no valid and no frame_err; a following 0x5A frame is received correctly.
- Frame 0x55 with stop bit 0, then rx held low for 3000 cycles → a single frame_err pulse, no valid. After rx returns high, frame 0x0F is received.
- ready=0, frames 0x41 then 0x42 back-to-back → data stays 0x41, one overrun pulse at the second stop sample. Raise ready → valid falls the next cycle.
- rst asserted mid-data-bit 4 of frame 0xC3, released while rx=1 → all outputs 0. The next frame 0x7E gives data=0x7E with no error.
